ifu_fetch: RTL and testbench

Instruction fetch unit sitting on the output side of the PC register: it consumes `pc_cur`, fetches the instruction at that address from instruction memory over a valid/ready request and a valid response channel, and presents it to decode with a valid/ready handshake. It also computes `pc_next` (hold, +4, or redirect) and feeds it back into the PC register every cycle. At most one memory request is outstanding.

---
 rtl/ifu_fetch.sv | 120 ++++++++++++
 tb/tb_ifu_fetch.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: requests the word at pc_cur from instruction memory,
// hands it to decode over valid/ready, and drives the PC register's next value.
module ifu_fetch #(
  parameter logic [31:0] PC_RST = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        fault_q, fault_d;
  logic        aligned;
  logic        req_hs;

  assign imem_req_addr = pc_cur;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_fault    = fault_q;
  assign aligned       = (pc_cur[1:0] == 2'b00);
  assign req_hs        = imem_req_valid && imem_req_ready;

  // State and delivered-instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      inst_q    <= 32'h0;
      inst_pc_q <= PC_RST;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
    end
  end

  // Next state, next PC, handshake outputs and instruction capture.
  always_comb begin
    state_d        = state_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    fault_d        = fault_q;
    pc_next        = pc_cur;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        imem_req_valid = aligned;
        if (redirect_valid) begin
          pc_next = redirect_pc;
          state_d = req_hs ? S_DROP : S_REQ;
        end else if (!aligned) begin
          inst_d    = 32'h0;
          inst_pc_d = pc_cur;
          fault_d   = 1'b1;
          state_d   = S_OUT;
        end else if (req_hs) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_next = redirect_pc;
          state_d = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          inst_d    = imem_rsp_err ? 32'h0 : imem_rsp_data;
          inst_pc_d = pc_cur;
          fault_d   = imem_rsp_err;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        inst_valid = 1'b1;
        if (redirect_valid) begin
          pc_next = redirect_pc;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_next = pc_cur + 32'd4;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_next = redirect_pc;
        if (imem_rsp_valid) state_d = S_REQ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a behavioural PC register
// and a hand-driven instruction memory.
module tb_ifu_fetch;

  localparam logic [31:0] PC_RST = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_rsp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // PC register shares the fetch unit's reset and loads pc_next every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_cur <= PC_RST;
    else        pc_cur <= pc_next;
  end

  ifu_fetch #(.PC_RST(PC_RST)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_cur         (pc_cur),
    .pc_next        (pc_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  // From REQ with an aligned PC: handshake, respond next cycle, land in OUT.
  task automatic run_to_out(input logic [31:0] d, input logic e);
    imem_req_ready = 1'b1;
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    imem_rsp_err   = e;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    settle();
  endtask

  task automatic accept;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    settle();
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #2;
    n_chk++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valids: inst_valid=%b req_valid=%b want 0 0",
               inst_valid, imem_req_valid);
    end
    n_chk++;
    if (inst !== 32'h0 || inst_pc !== PC_RST || inst_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: inst=%h pc=%h f=%b want 0 %h 0",
               inst, inst_pc, inst_fault, PC_RST);
    end
    rst_n = 1'b1;
    settle();
    n_chk++;
    if (imem_req_valid !== 1'b0 || pc_next !== PC_RST) begin
      n_fail++;
      $display("FAIL idle: req_valid=%b pc_next=%h want 0 %h",
               imem_req_valid, pc_next, PC_RST);
    end
  endtask

  task automatic test_first_fetch;
    tick();
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL first_req: v=%b a=%h want 1 80000000",
               imem_req_valid, imem_req_addr);
    end
    run_to_out(32'h0000_0013, 1'b0);
    n_chk++;
    if (inst_valid !== 1'b1 || inst !== 32'h13 ||
        inst_pc !== 32'h8000_0000 || inst_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL first_inst: v=%b i=%h pc=%h f=%b want 1 13 80000000 0",
               inst_valid, inst, inst_pc, inst_fault);
    end
    inst_ready = 1'b1;
    settle();
    n_chk++;
    if (pc_next !== 32'h8000_0004) begin
      n_fail++;
      $display("FAIL first_pcnext: got %h want 80000004", pc_next);
    end
    tick();
    inst_ready = 1'b0;
    settle();
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin
      n_fail++;
      $display("FAIL second_req: v=%b a=%h want 1 80000004",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_backpressure;
    run_to_out(32'h0010_0093, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 ||
          inst_pc !== 32'h8000_0004 || pc_next !== 32'h8000_0004 ||
          imem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: v=%b i=%h pc=%h nx=%h rq=%b",
                 i, inst_valid, inst, inst_pc, pc_next, imem_req_valid);
      end
      tick();
    end
    accept();
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008) begin
      n_fail++;
      $display("FAIL bp_next_req: v=%b a=%h want 1 80000008",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_wait;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    settle();
    n_chk++;
    if (pc_next !== 32'h8000_0100) begin
      n_fail++;
      $display("FAIL rw_pcnext: got %h want 80000100", pc_next);
    end
    tick();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    settle();
    n_chk++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_drop: rq=%b v=%b want 0 0",
               imem_req_valid, inst_valid);
    end
    tick();
    imem_rsp_valid = 1'b0;
    settle();
    n_chk++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 ||
        imem_req_addr !== 32'h8000_0100) begin
      n_fail++;
      $display("FAIL rw_req: v=%b rq=%b a=%h want 0 1 80000100",
               inst_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_accept;
    run_to_out(32'h0000_0013, 1'b0);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    settle();
    n_chk++;
    if (pc_next !== 32'h8000_0200) begin
      n_fail++;
      $display("FAIL ra_pcnext: got %h want 80000200", pc_next);
    end
    tick();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    settle();
    n_chk++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 ||
        imem_req_addr !== 32'h8000_0200) begin
      n_fail++;
      $display("FAIL ra_next: v=%b rq=%b a=%h want 0 1 80000200",
               inst_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_fault_misaligned;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    settle();
    n_chk++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h8000_0102) begin
      n_fail++;
      $display("FAIL mis_noreq: rq=%b a=%h want 0 80000102",
               imem_req_valid, imem_req_addr);
    end
    tick();
    n_chk++;
    if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || inst !== 32'h0 ||
        inst_pc !== 32'h8000_0102) begin
      n_fail++;
      $display("FAIL mis_inst: v=%b f=%b i=%h pc=%h want 1 1 0 80000102",
               inst_valid, inst_fault, inst, inst_pc);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    settle();
    n_chk++;
    if (inst_valid !== 1'b0 || imem_req_addr !== 32'h8000_0300) begin
      n_fail++;
      $display("FAIL mis_kill: v=%b a=%h want 0 80000300",
               inst_valid, imem_req_addr);
    end
  endtask

  task automatic test_fault_err;
    run_to_out(32'h1234_5678, 1'b1);
    n_chk++;
    if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || inst !== 32'h0 ||
        inst_pc !== 32'h8000_0300) begin
      n_fail++;
      $display("FAIL err_inst: v=%b f=%b i=%h pc=%h want 1 1 0 80000300",
               inst_valid, inst_fault, inst, inst_pc);
    end
    accept();
    n_chk++;
    if (imem_req_addr !== 32'h8000_0304 || imem_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL err_next: rq=%b a=%h want 1 80000304",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_wrap;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    settle();
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_req: rq=%b a=%h want 1 fffffffc",
               imem_req_valid, imem_req_addr);
    end
    run_to_out(32'h0000_0013, 1'b0);
    n_chk++;
    if (inst_pc !== 32'hFFFF_FFFC || inst !== 32'h13) begin
      n_fail++;
      $display("FAIL wrap_inst: pc=%h i=%h want fffffffc 13", inst_pc, inst);
    end
    inst_ready = 1'b1;
    settle();
    n_chk++;
    if (pc_next !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_pcnext: got %h want 00000000", pc_next);
    end
    tick();
    inst_ready = 1'b0;
    settle();
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_next: rq=%b a=%h want 1 00000000",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_async_reset;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || inst !== 32'h0 ||
        inst_pc !== PC_RST || inst_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_regs: v=%b rq=%b i=%h pc=%h f=%b",
               inst_valid, imem_req_valid, inst, inst_pc, inst_fault);
    end
    tick();
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0BAD;
    tick();
    imem_rsp_valid = 1'b0;
    settle();
    n_chk++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 ||
        imem_req_addr !== PC_RST) begin
      n_fail++;
      $display("FAIL arst_req: v=%b rq=%b a=%h want 0 1 %h",
               inst_valid, imem_req_valid, imem_req_addr, PC_RST);
    end
    run_to_out(32'h0000_0073, 1'b0);
    n_chk++;
    if (inst_valid !== 1'b1 || inst !== 32'h73 || inst_pc !== PC_RST) begin
      n_fail++;
      $display("FAIL arst_fetch: v=%b i=%h pc=%h want 1 73 %h",
               inst_valid, inst, inst_pc, PC_RST);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_accept();
    test_fault_misaligned();
    test_fault_err();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
